// File: rtl/de_stage_if.sv
// rtl/de_stage_if.sv - fetch/write-back/EX-side signal bundle for the decode stage
interface de_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              validIn_DE;
  logic              stall_DE;
  logic [5:0]        op_DE;
  logic [4:0]        rsDE;
  logic [4:0]        rtDE;
  logic [4:0]        rdDE;
  logic [4:0]        shamtDE;
  logic [5:0]        functDE;
  logic [ADDR_W-1:0] instAddrDE;
  logic              wbEnDE;
  logic [4:0]        wbAddrDE;
  logic [DATA_W-1:0] wbDataDE;

  logic              validOut_DE;
  logic [DATA_W-1:0] rsDataDE;
  logic [DATA_W-1:0] rtDataDE;
  logic [DATA_W-1:0] immDE;
  logic [4:0]        shamtOutDE;
  logic [4:0]        destRegDE;
  logic [3:0]        aluOpDE;
  logic              aluSrcDE;
  logic              regWriteDE;
  logic              memReadDE;
  logic              memWriteDE;
  logic              illegalDE;
  logic [ADDR_W-1:0] pcOutDE;

  modport master (
    output validIn_DE, stall_DE, op_DE, rsDE, rtDE, rdDE, shamtDE, functDE,
           instAddrDE, wbEnDE, wbAddrDE, wbDataDE,
    input  validOut_DE, rsDataDE, rtDataDE, immDE, shamtOutDE, destRegDE,
           aluOpDE, aluSrcDE, regWriteDE, memReadDE, memWriteDE, illegalDE, pcOutDE
  );

  modport slave (
    input  validIn_DE, stall_DE, op_DE, rsDE, rtDE, rdDE, shamtDE, functDE,
           instAddrDE, wbEnDE, wbAddrDE, wbDataDE,
    output validOut_DE, rsDataDE, rtDataDE, immDE, shamtOutDE, destRegDE,
           aluOpDE, aluSrcDE, regWriteDE, memReadDE, memWriteDE, illegalDE, pcOutDE
  );
endinterface

// File: rtl/de_stage.sv
// rtl/de_stage.sv - decode stage: register file, control decode, EX pipeline register
module de_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input logic    clk_DE,
  input logic    rst_DE,
  de_stage_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_NOP = 4'd7;

  logic [DATA_W-1:0] regFile [32];

  always_ff @(posedge clk_DE) begin
    if (rst_DE) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (bus.wbEnDE && bus.wbAddrDE != 5'd0) begin
      regFile[bus.wbAddrDE] <= bus.wbDataDE;
    end
  end

  // Same-cycle write-back is forwarded so the captured operand is never stale.
  logic [DATA_W-1:0] rsRead, rtRead;
  always_comb begin
    rsRead = '0;
    rtRead = '0;
    if (bus.rsDE != 5'd0)
      rsRead = (bus.wbEnDE && bus.wbAddrDE == bus.rsDE) ? bus.wbDataDE : regFile[bus.rsDE];
    if (bus.rtDE != 5'd0)
      rtRead = (bus.wbEnDE && bus.wbAddrDE == bus.rtDE) ? bus.wbDataDE : regFile[bus.rtDE];
  end

  logic [15:0]       immRaw;
  logic [DATA_W-1:0] immSext, immZext;
  logic              allZero;
  assign immRaw  = {bus.rdDE, bus.shamtDE, bus.functDE};
  assign immSext = {{(DATA_W-16){immRaw[15]}}, immRaw};
  assign immZext = {{(DATA_W-16){1'b0}}, immRaw};
  assign allZero = (bus.op_DE == 6'd0) && (bus.rsDE == 5'd0) && (bus.rtDE == 5'd0) &&
                   (immRaw == 16'd0);

  logic              dValid, dAluSrc, dRegWrite, dMemRead, dMemWrite, dIllegal;
  logic [3:0]        dAluOp;
  logic [4:0]        dDest;
  logic [DATA_W-1:0] dImm;

  always_comb begin
    dValid    = 1'b1;
    dImm      = immSext;
    dDest     = 5'd0;
    dAluOp    = ALU_NOP;
    dAluSrc   = 1'b0;
    dRegWrite = 1'b0;
    dMemRead  = 1'b0;
    dMemWrite = 1'b0;
    dIllegal  = 1'b0;
    case (bus.op_DE)
      OP_RTYPE: begin
        if (!allZero) begin
          dDest     = bus.rdDE;
          dRegWrite = (bus.rdDE != 5'd0);
          case (bus.functDE)
            6'b100000: dAluOp = ALU_ADD;
            6'b100010: dAluOp = ALU_SUB;
            6'b100100: dAluOp = ALU_AND;
            6'b100101: dAluOp = ALU_OR;
            6'b101010: dAluOp = ALU_SLT;
            6'b000000: dAluOp = ALU_SLL;
            default:   dIllegal = 1'b1;
          endcase
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
        dDest     = bus.rtDE;
        dAluSrc   = 1'b1;
        dRegWrite = (bus.rtDE != 5'd0);
        case (bus.op_DE)
          OP_ANDI: begin dAluOp = ALU_AND; dImm = immZext; end
          OP_ORI:  begin dAluOp = ALU_OR;  dImm = immZext; end
          OP_LW:   begin dAluOp = ALU_ADD; dMemRead = 1'b1; end
          default: dAluOp = ALU_ADD;
        endcase
      end
      OP_SW: begin
        dAluOp    = ALU_ADD;
        dAluSrc   = 1'b1;
        dMemWrite = 1'b1;
      end
      default: dIllegal = 1'b1;
    endcase
  end

  logic              vOut, aSrc, rWr, mRd, mWr, ill;
  logic [DATA_W-1:0] rsQ, rtQ, immQ;
  logic [4:0]        shQ, destQ;
  logic [3:0]        aluQ;
  logic [ADDR_W-1:0] pcQ;

  // An illegal slot carries no payload, only the flag, so EX sees a clean bubble.
  always_ff @(posedge clk_DE) begin
    if (rst_DE) begin
      vOut <= 1'b0; rsQ <= '0; rtQ <= '0; immQ <= '0; shQ <= '0; destQ <= '0;
      aluQ <= '0; aSrc <= 1'b0; rWr <= 1'b0; mRd <= 1'b0; mWr <= 1'b0;
      ill <= 1'b0; pcQ <= '0;
    end else if (bus.stall_DE) begin
      vOut <= vOut;
    end else if (!bus.validIn_DE || dIllegal) begin
      vOut <= 1'b0; rsQ <= '0; rtQ <= '0; immQ <= '0; shQ <= '0; destQ <= '0;
      aluQ <= ALU_NOP; aSrc <= 1'b0; rWr <= 1'b0; mRd <= 1'b0; mWr <= 1'b0;
      ill <= bus.validIn_DE && dIllegal; pcQ <= '0;
    end else begin
      vOut <= dValid; rsQ <= rsRead; rtQ <= rtRead; immQ <= dImm;
      shQ <= bus.shamtDE; destQ <= dDest; aluQ <= dAluOp; aSrc <= dAluSrc;
      rWr <= dRegWrite; mRd <= dMemRead; mWr <= dMemWrite; ill <= 1'b0;
      pcQ <= bus.instAddrDE;
    end
  end

  assign bus.validOut_DE = vOut;
  assign bus.rsDataDE    = rsQ;
  assign bus.rtDataDE    = rtQ;
  assign bus.immDE       = immQ;
  assign bus.shamtOutDE  = shQ;
  assign bus.destRegDE   = destQ;
  assign bus.aluOpDE     = aluQ;
  assign bus.aluSrcDE    = aSrc;
  assign bus.regWriteDE  = rWr;
  assign bus.memReadDE   = mRd;
  assign bus.memWriteDE  = mWr;
  assign bus.illegalDE   = ill;
  assign bus.pcOutDE     = pcQ;
endmodule

// File: tb/tb_de_stage.sv
// tb/tb_de_stage.sv - directed scoreboard bench for de_stage
module tb_de_stage;
  typedef struct packed {
    logic        valid;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [3:0]  aluOp;
    logic        aluSrc;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        illegal;
    logic [7:0]  pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t swE;

  de_stage_if #(.DATA_W(32), .ADDR_W(8)) bus ();
  de_stage #(.DATA_W(32), .ADDR_W(8)) dut (.clk_DE(clk), .rst_DE(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t mk(logic v, logic [31:0] rs, logic [31:0] rt, logic [31:0] imm,
                              logic [4:0] sh, logic [4:0] dest, logic [3:0] alu, logic src,
                              logic rw, logic mr, logic mw, logic il, logic [7:0] pc);
    exp_t e;
    e = '{valid: v, rsData: rs, rtData: rt, imm: imm, shamt: sh, dest: dest, aluOp: alu,
          aluSrc: src, regWrite: rw, memRead: mr, memWrite: mw, illegal: il, pc: pc};
    return e;
  endfunction

  function automatic exp_t observe();
    return mk(bus.validOut_DE, bus.rsDataDE, bus.rtDataDE, bus.immDE, bus.shamtOutDE,
              bus.destRegDE, bus.aluOpDE, bus.aluSrcDE, bus.regWriteDE, bus.memReadDE,
              bus.memWriteDE, bus.illegalDE, bus.pcOutDE);
  endfunction

  localparam exp_t ZERO    = '0;
  localparam exp_t BUBBLE  = exp_t'({1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 4'd7, 5'b00000, 8'd0});
  localparam exp_t ILLEGAL = exp_t'({1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 4'd7, 5'b00001, 8'd0});

  task automatic fields(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [7:0] pc);
    bus.op_DE = op; bus.rsDE = rs; bus.rtDE = rt; bus.rdDE = rd;
    bus.shamtDE = sh; bus.functDE = fn; bus.instAddrDE = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wbEnDE = en; bus.wbAddrDE = a; bus.wbDataDE = d;
  endtask

  task automatic cyc(input logic r, input logic v, input logic s, input exp_t e, input string tag);
    exp_t got, want;
    rst = r; bus.validIn_DE = v; bus.stall_DE = s;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = observe();
    want = sb.pop_front();
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
    wb(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.validIn_DE = 1'b0; bus.stall_DE = 1'b0;
    fields(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 8'd0);
    wb(1'b0, 5'd0, 32'd0);

    fields(6'h00, 5'd5, 5'd5, 5'd6, 5'd0, 6'h20, 8'h10);
    wb(1'b1, 5'd5, 32'h1234);
    cyc(1'b1, 1'b1, 1'b0, ZERO, "reset0");
    wb(1'b1, 5'd5, 32'h1234);
    cyc(1'b1, 1'b1, 1'b0, ZERO, "reset1");
    cyc(1'b0, 1'b1, 1'b0, mk(1, 0, 0, 32'h3020, 0, 6, 0, 0, 1, 0, 0, 0, 8'h10), "r5_cleared");

    wb(1'b1, 5'd3, 32'h7);
    cyc(1'b0, 1'b0, 1'b0, BUBBLE, "bubble_wb_r3");
    fields(6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20, 8'h14);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 7, 7, 32'h2020, 0, 4, 0, 0, 1, 0, 0, 0, 8'h14), "add_r3_r3");

    fields(6'h23, 5'd8, 5'd9, 5'h1F, 5'h1F, 6'h3C, 8'h18);
    wb(1'b1, 5'd8, 32'hDEADBEEF);
    cyc(1'b0, 1'b1, 1'b0,
        mk(1, 32'hDEADBEEF, 0, 32'hFFFFFFFC, 5'h1F, 9, 0, 1, 1, 1, 0, 0, 8'h18), "lw_bypass");

    wb(1'b1, 5'd0, 32'h55);
    cyc(1'b0, 1'b0, 1'b0, BUBBLE, "bubble_wb_r0");
    fields(6'h0D, 5'd0, 5'd10, 5'h10, 5'd0, 6'h01, 8'h1C);
    wb(1'b1, 5'd0, 32'h55);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 0, 0, 32'h8001, 0, 10, 3, 1, 1, 0, 0, 0, 8'h1C), "ori_r0");

    fields(6'h2B, 5'd3, 5'd8, 5'd0, 5'd0, 6'h10, 8'h20);
    swE = mk(1, 7, 32'hDEADBEEF, 32'h10, 0, 0, 0, 1, 0, 0, 1, 0, 8'h20);
    cyc(1'b0, 1'b1, 1'b0, swE, "sw");
    wb(1'b1, 5'd8, 32'h11111111);
    cyc(1'b0, 1'b1, 1'b1, swE, "stall0");
    wb(1'b1, 5'd2, 32'hABCD);
    cyc(1'b0, 1'b1, 1'b1, swE, "stall1");
    cyc(1'b0, 1'b1, 1'b1, swE, "stall2");
    cyc(1'b0, 1'b0, 1'b0, BUBBLE, "bubble_after_stall");
    fields(6'h00, 5'd2, 5'd8, 5'd1, 5'd0, 6'h20, 8'h24);
    cyc(1'b0, 1'b1, 1'b0,
        mk(1, 32'hABCD, 32'h11111111, 32'h0820, 0, 1, 0, 0, 1, 0, 0, 0, 8'h24), "stall_writes_landed");

    fields(6'h00, 5'd8, 5'd3, 5'd13, 5'd0, 6'h22, 8'h28);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 32'h11111111, 7, 32'h6822, 0, 13, 1, 0, 1, 0, 0, 0, 8'h28), "sub");
    fields(6'h00, 5'd3, 5'd2, 5'd0, 5'd0, 6'h24, 8'h2C);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 7, 32'hABCD, 32'h24, 0, 0, 2, 0, 0, 0, 0, 0, 8'h2C), "and_rd0");
    fields(6'h00, 5'd2, 5'd3, 5'd31, 5'd0, 6'h2A, 8'h30);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 32'hABCD, 7, 32'hFFFFF82A, 0, 31, 4, 0, 1, 0, 0, 0, 8'h30), "slt");
    fields(6'h00, 5'd0, 5'd3, 5'd5, 5'd4, 6'h00, 8'h34);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 0, 7, 32'h2900, 4, 5, 5, 0, 1, 0, 0, 0, 8'h34), "sll");
    fields(6'h0C, 5'd3, 5'd12, 5'h1E, 5'h03, 6'h30, 8'h38);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 7, 0, 32'h0000F0F0, 3, 12, 2, 1, 1, 0, 0, 0, 8'h38), "andi_zext");
    fields(6'h08, 5'd3, 5'd0, 5'h10, 5'd0, 6'h00, 8'h3C);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 7, 0, 32'hFFFF8000, 0, 0, 0, 1, 0, 0, 0, 0, 8'h3C), "addi_rt0");
    fields(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 8'h40);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 8'h40), "nop");
    fields(6'h02, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20, 8'h44);
    cyc(1'b0, 1'b1, 1'b0, ILLEGAL, "illegal_op");
    fields(6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h01, 8'h48);
    cyc(1'b0, 1'b1, 1'b0, ILLEGAL, "illegal_funct");

    fields(6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20, 8'h4C);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 7, 7, 32'h2020, 0, 4, 0, 0, 1, 0, 0, 0, 8'h4C), "add_before_rst");
    wb(1'b1, 5'd7, 32'h77);
    cyc(1'b1, 1'b1, 1'b1, ZERO, "reset_mid_stall");
    fields(6'h00, 5'd7, 5'd3, 5'd4, 5'd0, 6'h20, 8'h50);
    cyc(1'b0, 1'b1, 1'b0, mk(1, 0, 0, 32'h2020, 0, 4, 0, 0, 1, 0, 0, 0, 8'h50), "post_reset_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
